// File: rtl/ev22_pkg.sv
// Shared EV22 definitions: flow-control opcode patterns, sequencer FSM states
// and a small opcode classifier used by both the sequencer and the decoder.
package ev22_pkg;

    localparam int PC_W_DEFAULT = 10;

    // Flow-control opcode patterns, matched against the high byte of the word
    localparam logic [4:0] OP_JMP = 5'b00100;
    localparam logic [4:0] OP_JZE = 5'b00101;
    localparam logic [4:0] OP_JNE = 5'b00110;
    localparam logic [4:0] OP_JCY = 5'b00111;
    localparam logic [5:0] OP_BSR = 6'b000111;
    localparam logic [7:0] OP_RET = 8'h41;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } seq_state_e;

    typedef enum logic [2:0] {
        FL_SEQ,
        FL_JMP,
        FL_JZE,
        FL_JNE,
        FL_JCY,
        FL_BSR,
        FL_RET
    } flow_e;

    function automatic flow_e decode_flow(input logic [7:0] op_hi);
        flow_e f;
        f = FL_SEQ;
        if (op_hi[7:3] == OP_JMP)      f = FL_JMP;
        else if (op_hi[7:3] == OP_JZE) f = FL_JZE;
        else if (op_hi[7:3] == OP_JNE) f = FL_JNE;
        else if (op_hi[7:3] == OP_JCY) f = FL_JCY;
        else if (op_hi[7:2] == OP_BSR) f = FL_BSR;
        else if (op_hi == OP_RET)      f = FL_RET;
        return f;
    endfunction

    function automatic logic [15:0] sext10(input logic [9:0] v);
        return {{6{v[9]}}, v};
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO. Entry index is depth modulo DEPTH, so an overflowing
// push lands on entry 0 (the oldest) and an underflowing pop reads the top slot.
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         push_data_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic [$clog2(DEPTH):0]   depth_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      depth_q, depth_d;
    logic [AW-1:0]    wr_idx, rd_idx;

    assign wr_idx     = depth_q[AW-1:0];
    assign rd_idx     = wr_idx - AW'(1);
    assign full_o     = (depth_q == (AW+1)'(DEPTH));
    assign empty_o    = (depth_q == '0);
    assign depth_o    = depth_q;
    assign pop_data_o = mem_q[rd_idx];

    // Depth saturates at both ends; the caller decides whether that is legal
    always_comb begin
        depth_d = depth_q;
        if (push_i && !full_o)
            depth_d = depth_q + (AW+1)'(1);
        else if (pop_i && !empty_o)
            depth_d = depth_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            depth_q <= '0;
        else
            depth_q <= depth_d;
    end

    always_ff @(posedge clk) begin
        if (push_i && !reset)
            mem_q[wr_idx] <= push_data_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// EV22 program-counter sequencer: fetch sequencing, flow control and BSR/RET.
// Define PCSEQ_STACK_GUARD_EN to trap stack overflow/underflow into FAULT.
module pc_sequencer
    import ev22_pkg::*;
#(
    parameter int PC_W        = PC_W_DEFAULT,
    parameter int STACK_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [15:0]                    opcode,
    input  logic                           stall,
    input  logic                           w_zero,
    input  logic                           w_msb,
    input  logic                           cy,
    output logic [PC_W-1:0]                pc,
    output logic                           instr_valid,
    output logic [$clog2(STACK_DEPTH):0]   stack_depth,
    output logic                           fault
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc, pc_tgt, pc_bsr, pop_data;
    logic            push, pop, stk_full, stk_empty;
    flow_e           flow;

    assign flow   = decode_flow(opcode[15:8]);
    assign pc_inc = pc_q + PC_W'(1);
    assign pc_tgt = opcode[PC_W-1:0];
    // Relative call: 10-bit signed offset, wraps modulo 2^PC_W
    assign pc_bsr = PC_W'(16'(pc_q) + sext10(opcode[9:0]));

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_ret_stack (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_inc),
        .pop_data_o  (pop_data),
        .depth_o     (stack_depth),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        push        = 1'b0;
        pop         = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!stall) begin
                    instr_valid = 1'b1;
                    case (flow)
                        FL_JMP: pc_d = pc_tgt;
                        FL_JZE: pc_d = w_zero ? pc_tgt : pc_inc;
                        FL_JNE: pc_d = !w_msb ? pc_tgt : pc_inc;
                        FL_JCY: pc_d = cy ? pc_tgt : pc_inc;
                        FL_BSR: begin
`ifdef PCSEQ_STACK_GUARD_EN
                            if (stk_full) begin
                                state_d = FAULT;
                            end else begin
                                push = 1'b1;
                                pc_d = pc_bsr;
                            end
`else
                            push = 1'b1;
                            pc_d = pc_bsr;
`endif
                        end
                        FL_RET: begin
`ifdef PCSEQ_STACK_GUARD_EN
                            if (stk_empty) begin
                                state_d = FAULT;
                            end else begin
                                pop  = 1'b1;
                                pc_d = pop_data;
                            end
`else
                            pop  = 1'b1;
                            pc_d = pop_data;
`endif
                        end
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc = pc_q;

`ifdef PCSEQ_STACK_GUARD_EN
    assign fault = (state_q == FAULT);
`else
    // Without the guard the stack limits are never consulted
    logic unused_stk_flags;
    assign unused_stk_flags = stk_full ^ stk_empty;
    assign fault            = 1'b0;
`endif

endmodule
